// File: rtl/ldr_day_night_detector_pkg.sv
// Shared smart-home sensor types: debounced light-state encoding and LDR polarity.
package smarthome_pkg;

  typedef enum logic [1:0] {
    DAY      = 2'd0,
    TO_NIGHT = 2'd1,
    NIGHT    = 2'd2,
    TO_DAY   = 2'd3
  } ldr_state_t;

  localparam logic LDR_DARK = 1'b1;

  // Pending states still report the state being left.
  function automatic logic state_is_night(input ldr_state_t s);
    return (s == NIGHT) || (s == TO_DAY);
  endfunction

endpackage

// File: rtl/ldr_day_night_detector_if.sv
// Day/night change event channel: valid/ready handshake with a one-bit payload.
interface ldr_day_night_detector_if;

  logic EVT_VALID;
  logic EVT_NIGHT;
  logic EVT_READY;

  modport master (output EVT_VALID, output EVT_NIGHT, input EVT_READY);
  modport slave  (input EVT_VALID, input EVT_NIGHT, output EVT_READY);

endinterface

// File: rtl/ldr_day_night_detector_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ldr_day_night_detector.sv
// LDR day/night detector: sync, debounce FSM, change event with overflow flag and counter.
// Optional post-flip input holdoff is enabled by defining LDR_HOLDOFF_EN.
//
//  state    | meaning
//  DAY      | light, waiting for a dark sample
//  TO_NIGHT | counting consecutive dark samples
//  NIGHT    | dark, waiting for a light sample
//  TO_DAY   | counting consecutive light samples
module ldr_day_night_detector
  import smarthome_pkg::*;
#(
  parameter int DEBOUNCE_N = 3,
  parameter int CNT_W      = 8,
  parameter int HOLDOFF_N  = 5
) (
  input  logic                     CLK_IN_1HZ,
  input  logic                     RST,
  input  logic                     LDR,
  output logic                     NIGHT,
  ldr_day_night_detector_if.master evt,
  output logic                     EVT_OVF,
  output logic [CNT_W-1:0]         TRANS_CNT
);

  localparam int               CW       = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_N - 1);

  ldr_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ldr_s;
  logic             flip;
  logic             sample_en;
  logic             evt_valid_q, evt_night_q, ovf_q;
  logic [CNT_W-1:0] trans_q;

  sync_2ff u_sync (
    .clk (CLK_IN_1HZ),
    .rst (RST),
    .d   (LDR),
    .q   (ldr_s)
  );

`ifdef LDR_HOLDOFF_EN
  localparam int HW = (HOLDOFF_N > 0) ? $clog2(HOLDOFF_N + 1) : 1;

  logic [HW-1:0] holdoff_q;

  always_ff @(posedge CLK_IN_1HZ) begin
    if (RST)
      holdoff_q <= '0;
    else if (flip)
      holdoff_q <= HW'(HOLDOFF_N);
    else if (holdoff_q != '0)
      holdoff_q <= holdoff_q - HW'(1);
  end

  assign sample_en = (holdoff_q == '0);
`else
  assign sample_en = 1'b1;
`endif

  always_ff @(posedge CLK_IN_1HZ) begin
    if (RST) begin
      state_q <= DAY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // With DEBOUNCE_N=1 the pending states are never entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        DAY: begin
          if (ldr_s == LDR_DARK) begin
            if (DEBOUNCE_N == 1) begin
              state_d = smarthome_pkg::NIGHT;
              flip    = 1'b1;
            end else begin
              state_d = TO_NIGHT;
              cnt_d   = CW'(1);
            end
          end
        end
        TO_NIGHT: begin
          if (ldr_s != LDR_DARK) begin
            state_d = DAY;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = smarthome_pkg::NIGHT;
            cnt_d   = '0;
            flip    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        smarthome_pkg::NIGHT: begin
          if (ldr_s != LDR_DARK) begin
            if (DEBOUNCE_N == 1) begin
              state_d = DAY;
              flip    = 1'b1;
            end else begin
              state_d = TO_DAY;
              cnt_d   = CW'(1);
            end
          end
        end
        TO_DAY: begin
          if (ldr_s == LDR_DARK) begin
            state_d = smarthome_pkg::NIGHT;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DAY;
            cnt_d   = '0;
            flip    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = DAY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A flip always wins over an accept; overflow only when the old event was not taken.
  always_ff @(posedge CLK_IN_1HZ) begin
    if (RST) begin
      evt_valid_q <= 1'b0;
      evt_night_q <= 1'b0;
      ovf_q       <= 1'b0;
      trans_q     <= '0;
    end else if (flip) begin
      if (evt_valid_q && !evt.EVT_READY)
        ovf_q <= 1'b1;
      evt_valid_q <= 1'b1;
      evt_night_q <= state_is_night(state_d);
      trans_q     <= trans_q + CNT_W'(1);
    end else if (evt_valid_q && evt.EVT_READY) begin
      evt_valid_q <= 1'b0;
    end
  end

  always_comb begin
    NIGHT         = state_is_night(state_q);
    evt.EVT_VALID = evt_valid_q;
    evt.EVT_NIGHT = evt_night_q;
    EVT_OVF       = ovf_q;
    TRANS_CNT     = trans_q;
  end

endmodule

// File: tb/tb_ldr_day_night_detector.sv
// Randomised and directed bench for ldr_day_night_detector against a run-length reference model.
module tb_ldr_day_night_detector;

  localparam int DEB    = 3;
  localparam int CW     = 8;
  localparam int HOLD_N = 5;
`ifdef LDR_HOLDOFF_EN
  localparam int HOLD = HOLD_N;
`else
  localparam int HOLD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ldr = 1'b0;
  logic          night;
  logic          ovf;
  logic [CW-1:0] trans;

  ldr_day_night_detector_if evt_if ();

  always #5 clk = ~clk;

  ldr_day_night_detector #(
    .DEBOUNCE_N (DEB),
    .CNT_W      (CW),
    .HOLDOFF_N  (HOLD_N)
  ) dut (
    .CLK_IN_1HZ (clk),
    .RST        (rst),
    .LDR        (ldr),
    .NIGHT      (night),
    .evt        (evt_if),
    .EVT_OVF    (ovf),
    .TRANS_CNT  (trans)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: LDR reaches the debouncer two edges late; a flip needs DEB
  // consecutive samples disagreeing with the current state.
  bit m_hist[$];
  bit m_night, m_valid, m_payload, m_ovf;
  int m_run, m_hold, m_trans;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist    = '{1'b0, 1'b0};
    m_night   = 1'b0;
    m_valid   = 1'b0;
    m_payload = 1'b0;
    m_ovf     = 1'b0;
    m_run     = 0;
    m_hold    = 0;
    m_trans   = 0;
  endtask

  task automatic model_edge(input bit l, input bit r, input bit rs);
    bit s;
    bit flipped;
    flipped = 1'b0;
    if (rs) begin
      model_reset();
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(l);
      if (m_hold > 0) begin
        m_hold--;
        m_run = 0;
      end else if (s != m_night) begin
        m_run++;
        if (m_run == DEB) begin
          flipped = 1'b1;
          m_night = !m_night;
          m_run   = 0;
          m_hold  = HOLD;
        end
      end else begin
        m_run = 0;
      end
      if (flipped) begin
        if (m_valid && !r) m_ovf = 1'b1;
        m_valid   = 1'b1;
        m_payload = m_night;
        m_trans++;
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input bit l, input bit r, input bit rs);
    ldr              = l;
    evt_if.EVT_READY = r;
    rst              = rs;
    @(posedge clk);
    model_edge(l, r, rs);
    @(negedge clk);
    check("night",     night,            m_night);
    check("evt_valid", evt_if.EVT_VALID, m_valid);
    check("evt_night", evt_if.EVT_NIGHT, m_payload);
    check("evt_ovf",   ovf,              m_ovf);
    check("trans_cnt", trans,            m_trans % 256);
  endtask

  initial begin
    int fall;
    int per;
    int run_len;
    bit lvl;
    evt_if.EVT_READY = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_night", night, 0);
    check("rst_valid", evt_if.EVT_VALID, 0);
    check("rst_ovf",   ovf, 0);
    check("rst_trans", trans, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Step to dark, consumer always ready
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 0);
      if (k == 4) check("t2_night_e4", night, 0);
      if (k == 5) begin
        check("t2_night_e5", night, 1);
        check("t2_valid_e5", evt_if.EVT_VALID, 1);
        check("t2_payload",  evt_if.EVT_NIGHT, 1);
      end
      if (k == 6) begin
        check("t2_valid_e6", evt_if.EVT_VALID, 0);
        check("t2_trans",    trans, 1);
      end
    end

    // Short light glitch
    step(0, 1, 0);
    step(0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 0);
      check("t3_night", night, 1);
      check("t3_valid", evt_if.EVT_VALID, 0);
      check("t3_trans", trans, 1);
    end

    // Overwrite of an unaccepted event
    for (int k = 1; k <= 5; k++) step(0, 0, 0);
    check("t4_valid1",   evt_if.EVT_VALID, 1);
    check("t4_payload1", evt_if.EVT_NIGHT, 0);
    check("t4_ovf1",     ovf, 0);
    for (int k = 1; k <= 5 + HOLD; k++) step(1, 0, 0);
    check("t4_payload2", evt_if.EVT_NIGHT, 1);
    check("t4_ovf2",     ovf, 1);
    check("t4_trans",    trans, 3);
    step(1, 1, 0);
    check("t4_valid_clr", evt_if.EVT_VALID, 0);
    check("t4_ovf_stick", ovf, 1);

    // Reset in the middle of debouncing
    step(0, 1, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    check("t5_night", night, 0);
    check("t5_valid", evt_if.EVT_VALID, 0);
    check("t5_ovf",   ovf, 0);
    check("t5_trans", trans, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 0);
      check("t5_rise", night, (k >= 5) ? 1 : 0);
    end

    // Immediate return to light after a flip (holdoff window when enabled)
    fall = ((HOLD + 1 > 3) ? HOLD + 1 : 3) + 2;
    for (int k = 1; k <= fall + 1; k++) begin
      step(0, 1, 0);
      check("t6_night", night, (k < fall) ? 1 : 0);
    end

    // Counter wrap: 300 clean flips without reset
    step(0, 1, 1);
    per = 10 + 2 * HOLD;
    lvl = 1'b0;
    for (int f = 0; f < 300; f++) begin
      lvl = !lvl;
      for (int k = 0; k < per; k++) step(lvl, ($urandom_range(0, 3) != 0), 0);
    end
    check("wrap_trans", trans, 300 % 256);

    // Random runs, random ready, occasional reset
    lvl = 1'b0;
    for (int n = 0; n < 300; n++) begin
      lvl     = !lvl;
      run_len = $urandom_range(1, 2 * DEB + HOLD);
      for (int k = 0; k < run_len; k++)
        step(lvl, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
